// File: rtl/button_reader.sv
// -----------------------------------------------------------------------------
// button_reader
//   Debounces one raw, active-low push-button and turns it into clean events:
//   a debounced "pressed" level, one-cycle press / release / long-press strobes,
//   and a wrapping press counter wide enough to drive the 5-LED bus directly.
//   Runs on the raw system clock with no divider.
//
// Ports
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_btn            raw button pin, active-low (0 = pushed), asynchronous
//   i_clr            synchronous clear of the press counter, active-high
//   o_pressed        debounced level, 1 while the button is accepted as down
//   o_press_pulse    one-cycle strobe on an accepted press
//   o_release_pulse  one-cycle strobe on an accepted release
//   o_long_pulse     one-cycle strobe when a press is held long enough
//   o_press_count    accepted presses, modulo 2**COUNT_W
//   o_state          current FSM state (debug visibility)
//
// Handshake: none. All outputs are plain registered levels/strobes, valid every
// cycle; there is no valid/ready pairing on this block.
// -----------------------------------------------------------------------------
module button_reader #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64,
  parameter int COUNT_W           = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_btn,
  input  logic               i_clr,
  output logic               o_pressed,
  output logic               o_press_pulse,
  output logic               o_release_pulse,
  output logic               o_long_pulse,
  output logic [COUNT_W-1:0] o_press_count,
  output logic [1:0]         o_state
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  // The debounce counter is compared before its increment, so the accepting
  // edge is the one where the stored value is one short of the target.
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_long_fired;
  logic               r_pressed;
  logic               r_press_pulse;
  logic               r_release_pulse;
  logic               r_long_pulse;
  logic [COUNT_W-1:0] r_press_count;

  logic               w_active;
  logic               w_press_evt;
  logic [HOLD_W-1:0]  w_hold_next;

  // Synchronizer flops reset to 1 so a reset looks like "button released".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_active    = ~r_sync2;
  assign w_press_evt = (r_state == S_PRESS_WAIT) && w_active && (r_deb_cnt == DEB_LAST);
  // Hold time saturates so a very long press never wraps into a second long event.
  assign w_hold_next = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_deb_cnt       <= '0;
      r_hold_cnt      <= '0;
      r_long_fired    <= 1'b0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_active) begin
            r_state   <= S_PRESS_WAIT;
            r_deb_cnt <= DEB_W'(1);
          end
        end

        S_PRESS_WAIT: begin
          if (!w_active) begin
            r_state   <= S_IDLE;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
            if (r_deb_cnt == DEB_LAST) begin
              r_state       <= S_HELD;
              r_press_pulse <= 1'b1;
              r_pressed     <= 1'b1;
              r_hold_cnt    <= '0;
              r_long_fired  <= 1'b0;
            end
          end
        end

        S_HELD: begin
          if (w_active) begin
            r_hold_cnt <= w_hold_next;
            if ((w_hold_next == HOLD_MAX) && !r_long_fired) begin
              r_long_pulse <= 1'b1;
              r_long_fired <= 1'b1;
            end
          end else begin
            r_state   <= S_RELEASE_WAIT;
            r_deb_cnt <= DEB_W'(1);
          end
        end

        S_RELEASE_WAIT: begin
          // A bounce back to active resumes the same press: hold time and the
          // long-press flag survive, so no second long event is possible.
          if (w_active) begin
            r_state   <= S_HELD;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
            if (r_deb_cnt == DEB_LAST) begin
              r_state         <= S_IDLE;
              r_release_pulse <= 1'b1;
              r_pressed       <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // A press coinciding with clear is kept, so the count restarts at 1.
      if (w_press_evt) begin
        r_press_count <= i_clr ? COUNT_W'(1) : r_press_count + 1'b1;
      end else if (i_clr) begin
        r_press_count <= '0;
      end
    end
  end

  assign o_pressed       = r_pressed;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;
  assign o_long_pulse    = r_long_pulse;
  assign o_press_count   = r_press_count;
  assign o_state         = r_state;

endmodule
